// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: instruction encodings,
// error codes, FSM states, the bus command payload and small decode helpers.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } lsu_state_e;

    // Payload presented on the data-memory bus while a request is open.
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_cmd_t;

    // funct3 values accepted for the given access direction.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // funct3[1:0] gives the access size; bytes can never be misaligned.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_ldext.sv
// Load data extraction: selects the addressed byte/half of a bus word and
// sign- or zero-extends it according to funct3.
//   funct3_i : load funct3
//   off_i    : byte offset within the word (addr[1:0])
//   word_i   : raw word read from memory
//   result_o : extended 32-bit load result (combinational)
module lsu_ctrl_ldext
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        off_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[7:0];
        case (off_i)
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            2'd3:    byte_v = word_i[31:24];
            default: byte_v = word_i[7:0];
        endcase
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_LB:   result_o = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  result_o = {24'h0, byte_v};
            F3_LH:   result_o = {{16{half_v[15]}}, half_v};
            F3_LHU:  result_o = {16'h0, half_v};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the multi-cycle control unit and the data bus.
// Latches an access on start, checks legality/alignment for one cycle, runs a
// single req/ack bus transaction (with optional timeout) and reports done/err.
//   clock, reset        : clock, asynchronous active-high reset
//   start, ir, addr,    : access request (ir opcode/funct3, byte address,
//   wdata                 store data), sampled only while idle
//   busy, done, err,    : status back to the controller
//   err_code, rdata
//   mem_req, mem_we,    : data-memory bus request side
//   mem_addr, mem_wdata,
//   mem_wstrb
//   mem_ack, mem_rdata  : data-memory bus response side
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       ir,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    lsu_state_e state_q, state_d;

    logic [2:0]        f3_q;
    logic              store_q;
    logic              op_ok_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    mem_cmd_t          cmd_q, cmd_d, st_cmd;

    logic              accept;
    logic              chk_illegal;
    logic              chk_misalign;
    logic              timeout_hit;
    logic [DATA_W-1:0] ld_val;

    // Only opcode and funct3 of the instruction are decoded here.
    logic unused_ir;
    assign unused_ir = ^{ir[31:15], ir[11:7]};

    assign accept       = (state_q == ST_IDLE) && start;
    assign chk_illegal  = !op_ok_q || !f3_legal(store_q, f3_q);
    assign chk_misalign = misaligned(f3_q, addr_q[1:0]);
    // TIMEOUT of 0 disables the abort entirely.
    assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    lsu_ctrl_ldext u_ldext (
        .funct3_i (f3_q),
        .off_i    (addr_q[1:0]),
        .word_i   (mem_rdata),
        .result_o (ld_val)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack in the timeout cycle still completes the access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: state_d = (chk_illegal || chk_misalign) ? ST_ERR : ST_REQ;
            ST_REQ: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; everything is registered from state_d.
    always_comb begin
        st_cmd       = '0;
        st_cmd.we    = store_q;
        st_cmd.addr  = {addr_q[DATA_W-1:2], 2'b00};
        if (store_q) begin
            case (f3_q[1:0])
                2'b00: begin
                    st_cmd.wdata = {4{wdata_q[7:0]}};
                    st_cmd.wstrb = 4'b0001 << addr_q[1:0];
                end
                2'b01: begin
                    st_cmd.wdata = {2{wdata_q[15:0]}};
                    st_cmd.wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_cmd.wdata = wdata_q;
                    st_cmd.wstrb = 4'b1111;
                end
            endcase
        end

        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE) || (state_d == ST_ERR);
        err_d     = (state_d == ST_ERR);
        mem_req_d = (state_d == ST_REQ);
        // Latched inputs are frozen outside IDLE, so the command is stable.
        cmd_d     = (state_d == ST_REQ) ? st_cmd : '0;
        cnt_d     = (state_q == ST_REQ) ? cnt_q + CNT_W'(1) : '0;

        rdata_d = rdata_q;
        if ((state_q == ST_REQ) && mem_ack && !store_q) begin
            rdata_d = ld_val;
        end

        err_code_d = err_code_q;
        if (accept) begin
            err_code_d = ERR_NONE;
        end else if (state_q == ST_CHECK) begin
            if (chk_illegal) begin
                err_code_d = ERR_ILLEGAL;
            end else if (chk_misalign) begin
                err_code_d = ERR_MISALIGN;
            end
        end else if ((state_q == ST_REQ) && !mem_ack && timeout_hit) begin
            err_code_d = ERR_TIMEOUT;
        end
    end

    // Access latches and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f3_q       <= '0;
            store_q    <= 1'b0;
            op_ok_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            rdata_q    <= '0;
            mem_req_q  <= 1'b0;
            cmd_q      <= '0;
        end else begin
            if (accept) begin
                f3_q    <= ir[14:12];
                store_q <= (ir[6:0] == OPC_STORE);
                op_ok_q <= (ir[6:0] == OPC_STORE) || (ir[6:0] == OPC_LOAD);
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            rdata_q    <= rdata_d;
            mem_req_q  <= mem_req_d;
            cmd_q      <= cmd_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_wstrb = cmd_q.wstrb;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized accesses
// compared against a byte-level behavioural model of the load/store rules.
module tb_lsu_ctrl;

    localparam int unsigned TO = 16;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] ir, addr, wdata;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rd = 32'h0;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .ir        (ir),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One access: model predicts the outcome, bench plays the memory with
    // 'waits' stalled REQ cycles before ack (waits >= TO means never ack in time).
    task automatic access(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits,
                          input bit extra_start, input string tag);
        bit          is_store, is_load, legal;
        int          size, off, exp_lat, exp_reqs, req_seen, done_at;
        logic [1:0]  exp_code, got_code;
        logic        got_err;
        logic [31:0] exp_wdata, loaded;
        logic [3:0]  exp_wstrb;
        bit          stray;

        is_store = (opc == STORE);
        is_load  = (opc == LOAD);
        legal    = (is_load && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
                   (is_store && (f3 inside {3'd0, 3'd1, 3'd2}));
        size     = 1 << f3[1:0];
        off      = int'(a[1:0]);
        if (!legal)                 exp_code = 2'b10;
        else if (off % size != 0)   exp_code = 2'b01;
        else if (waits >= int'(TO)) exp_code = 2'b11;
        else                        exp_code = 2'b00;

        if (exp_code == 2'b01 || exp_code == 2'b10) begin
            exp_lat = 2; exp_reqs = 0;
        end else if (exp_code == 2'b11) begin
            exp_lat = 2 + int'(TO); exp_reqs = int'(TO);
        end else begin
            exp_lat = waits + 3; exp_reqs = waits + 1;
        end

        exp_wdata = '0;
        exp_wstrb = '0;
        for (int i = 0; i < 4; i++) begin
            exp_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
            exp_wstrb[i] = is_store && (i >= off) && (i < off + size);
        end

        loaded = rd >> (8 * off);
        if (size == 1)
            loaded = f3[2] ? {24'h0, loaded[7:0]} : {{24{loaded[7]}}, loaded[7:0]};
        else if (size == 2)
            loaded = f3[2] ? {16'h0, loaded[15:0]} : {{16{loaded[15]}}, loaded[15:0]};

        @(negedge clock);
        ir = $urandom;
        ir[14:12] = f3;
        ir[6:0] = opc;
        addr = a;
        wdata = wd;
        start = 1'b1;
        req_seen = 0;
        done_at = 0;
        got_err = 1'b0;
        got_code = 2'b00;
        for (int k = 1; k <= 60 && done_at == 0; k++) begin
            @(negedge clock);
            start = extra_start && (k == 1);
            if (start) begin
                ir[6:0] = STORE;
                ir[14:12] = 3'b010;
                addr = a ^ 32'h0000_0100;
            end
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                req_seen++;
                check($sformatf("%s.mem_addr", tag), mem_addr, {a[31:2], 2'b00});
                check($sformatf("%s.mem_we", tag), 32'(mem_we), 32'(is_store));
                check($sformatf("%s.mem_wstrb", tag), 32'(mem_wstrb), 32'(exp_wstrb));
                if (is_store) check($sformatf("%s.mem_wdata", tag), mem_wdata, exp_wdata);
                if (req_seen == waits + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
            end
            if (done) begin
                done_at = k;
                got_err = err;
                got_code = err_code;
            end
        end
        mem_ack = 1'b0;
        start = 1'b0;

        if (exp_code == 2'b00 && is_load) exp_rd = loaded;
        check($sformatf("%s.latency", tag), 32'(done_at), 32'(exp_lat));
        check($sformatf("%s.req_cycles", tag), 32'(req_seen), 32'(exp_reqs));
        check($sformatf("%s.err", tag), 32'(got_err), 32'(exp_code != 2'b00));
        check($sformatf("%s.err_code", tag), 32'(got_code), 32'(exp_code));
        check($sformatf("%s.rdata", tag), rdata, exp_rd);

        @(negedge clock);
        check($sformatf("%s.done_pulse", tag), 32'({done, err, busy, mem_req}), 32'h0);
        check($sformatf("%s.err_code_hold", tag), 32'(err_code), 32'(exp_code));

        if (extra_start) begin
            stray = 1'b0;
            repeat (5) begin
                @(negedge clock);
                if (mem_req || done || busy) stray = 1'b1;
            end
            check($sformatf("%s.ignored_start", tag), 32'(stray), 32'h0);
        end
    endtask

    initial begin
        logic [6:0]  r_opc;
        logic [2:0]  r_f3;
        logic [31:0] r_a;
        int          r_w, r;
        bit          seen;

        reset = 1'b1;
        start = 1'b0;
        ir = '0;
        addr = '0;
        wdata = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;

        // Reset state.
        repeat (2) @(negedge clock);
        check("reset.status", 32'({busy, done, err, err_code, mem_req, mem_we}), 32'h0);
        check("reset.bus", mem_addr | mem_wdata | 32'(mem_wstrb), 32'h0);
        check("reset.rdata", rdata, 32'h0);
        reset = 1'b0;

        // Ack while idle must not start anything.
        @(negedge clock);
        mem_ack = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (busy || done || mem_req) seen = 1'b1;
        end
        mem_ack = 1'b0;
        check("idle_ack.ignored", 32'(seen), 32'h0);

        // Directed scenarios.
        access(LOAD,  3'b000, 32'h0000_1003, 32'h0,         32'h80FF_1234, 2,  0, "lb");
        check("lb.value", rdata, 32'hFFFF_FF80);
        access(LOAD,  3'b101, 32'h0000_2002, 32'h0,         32'hBEEF_0000, 0,  0, "lhu");
        check("lhu.value", rdata, 32'h0000_BEEF);
        access(LOAD,  3'b001, 32'h0000_2002, 32'h0,         32'hBEEF_0000, 1,  0, "lh");
        check("lh.value", rdata, 32'hFFFF_BEEF);
        access(STORE, 3'b000, 32'h0000_0011, 32'h1234_56AB, 32'h0,         0,  0, "sb");
        access(STORE, 3'b001, 32'h0000_0022, 32'hCAFE_5678, 32'h0,         1,  0, "sh");
        access(STORE, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         0,  0, "sw");
        access(LOAD,  3'b010, 32'h0000_3002, 32'h0,         32'h1111_2222, 0,  0, "lw_misalign");
        access(STORE, 3'b001, 32'h0000_3001, 32'h0,         32'h0,         0,  0, "sh_misalign");
        access(LOAD,  3'b011, 32'h0000_3000, 32'h0,         32'h0,         0,  0, "ld_f3_illegal");
        access(STORE, 3'b100, 32'h0000_3000, 32'h0,         32'h0,         0,  0, "st_f3_illegal");
        access(7'b0110011, 3'b000, 32'h0000_3000, 32'h0,   32'h0,         0,  0, "bad_opcode");
        access(LOAD,  3'b010, 32'h0000_4000, 32'h0,         32'h1234_5678, 100, 0, "timeout");
        access(LOAD,  3'b010, 32'h0000_4004, 32'h0,         32'h8765_4321, int'(TO) - 1, 0, "ack_last");
        access(LOAD,  3'b100, 32'h0000_5001, 32'h0,         32'hAA55_C3F0, 0,  1, "busy_start");

        // Reset during REQ drops the request immediately and yields no done.
        @(negedge clock);
        ir = '0;
        ir[14:12] = 3'b010;
        ir[6:0] = LOAD;
        addr = 32'h0000_0080;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_req.req_before", 32'(mem_req), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_req.req_drop", 32'({mem_req, busy}), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (done || mem_req || busy) seen = 1'b1;
        end
        check("rst_req.no_done", 32'(seen), 32'h0);
        exp_rd = 32'h0;
        check("rst_req.rdata", rdata, exp_rd);

        // Randomized accesses against the model.
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            r_opc = (r < 5) ? LOAD : (r < 9) ? STORE : 7'($urandom);
            r_f3 = 3'($urandom);
            r_a = $urandom;
            if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
            r_w = ($urandom_range(0, 7) == 0) ? int'(TO) + int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, 3));
            access(r_opc, r_f3, r_a, $urandom, $urandom, r_w, 0, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
